spike_rate_encoder: RTL and testbench

- Upstream stimulus stage for the perceptron neuron. It converts two captured input intensities into deterministic rate-coded spike trains, which drive the neuron's v_in1/v_in2 inputs.
- Each stimulus is presented as a frame: a fixed number of enabled run cycles followed by a fixed silent rest period. The rest period lets the neuron state settle between stimuli.
- Spike rate per channel is int/2^IN_W, generated by phase accumulators. No randomness is used, so spike trains are exactly reproducible.

---
 rtl/spike_rate_encoder_if.sv | 31 +++
 rtl/spike_rate_encoder.sv | 142 ++++++++++++++
 tb/tb_spike_rate_encoder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/spike_rate_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : spike_rate_encoder_if
//  Description : Control/stimulus bundle between a frame driver and the
//                spike rate encoder (load/enable/intensities in, spikes and
//                frame status out).
//  Revision    : 1.0 - initial release
// ============================================================================
interface spike_rate_encoder_if #(
    parameter int IN_W = 4
) ();
    logic            en;
    logic            load;
    logic [IN_W-1:0] int1;
    logic [IN_W-1:0] int2;
    logic            v_out1;
    logic            v_out2;
    logic            busy;
    logic            frame_done;

    modport master (
        output en, load, int1, int2,
        input  v_out1, v_out2, busy, frame_done
    );

    modport slave (
        input  en, load, int1, int2,
        output v_out1, v_out2, busy, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/spike_rate_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : spike_rate_encoder
//  Description : Converts two captured intensities into deterministic
//                rate-coded spike trains using phase accumulators. Each
//                stimulus is a frame of FRAME_LEN enabled RUN cycles followed
//                by REST_LEN silent cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_rate_encoder #(
    parameter int IN_W      = 4,
    parameter int FRAME_LEN = 16,
    parameter int REST_LEN  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spike_rate_encoder_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_REST = 2'd2
    } state_t;

    localparam int RUN_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int REST_W = (REST_LEN  > 1) ? $clog2(REST_LEN)  : 1;
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(FRAME_LEN - 1);
    localparam logic [REST_W-1:0] REST_LAST = REST_W'(REST_LEN - 1);

    state_t            state_q,  state_d;
    logic [IN_W-1:0]   acc1_q,   acc1_d;
    logic [IN_W-1:0]   acc2_q,   acc2_d;
    logic [IN_W-1:0]   int1_q,   int1_d;
    logic [IN_W-1:0]   int2_q,   int2_d;
    logic [RUN_W-1:0]  run_cnt_q,  run_cnt_d;
    logic [REST_W-1:0] rest_cnt_q, rest_cnt_d;
    logic              v1_q,   v1_d;
    logic              v2_q,   v2_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // One extra bit so the accumulator carry becomes the spike.
    logic [IN_W:0]     w_sum1;
    logic [IN_W:0]     w_sum2;

    assign w_sum1 = {1'b0, acc1_q} + {1'b0, int1_q};
    assign w_sum2 = {1'b0, acc2_q} + {1'b0, int2_q};

    // State register: reset aborts any frame in progress without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc1_q     <= '0;
            acc2_q     <= '0;
            int1_q     <= '0;
            int2_q     <= '0;
            run_cnt_q  <= '0;
            rest_cnt_q <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc1_q     <= acc1_d;
            acc2_q     <= acc2_d;
            int1_q     <= int1_d;
            int2_q     <= int2_d;
            run_cnt_q  <= run_cnt_d;
            rest_cnt_q <= rest_cnt_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state and registered-output decode; spikes default to silent.
    always_comb begin
        state_d    = state_q;
        acc1_d     = acc1_q;
        acc2_d     = acc2_q;
        int1_d     = int1_q;
        int2_d     = int2_q;
        run_cnt_d  = run_cnt_q;
        rest_cnt_d = rest_cnt_q;
        v1_d       = 1'b0;
        v2_d       = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Load is only honoured here, so a load held through a
                // frame's done pulse starts the next frame back-to-back.
                if (bus.load) begin
                    int1_d    = bus.int1;
                    int2_d    = bus.int2;
                    acc1_d    = '0;
                    acc2_d    = '0;
                    run_cnt_d = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.en) begin
                    v1_d      = w_sum1[IN_W];
                    v2_d      = w_sum2[IN_W];
                    acc1_d    = w_sum1[IN_W-1:0];
                    acc2_d    = w_sum2[IN_W-1:0];
                    run_cnt_d = run_cnt_q + RUN_W'(1);
                    if (run_cnt_q == RUN_LAST) begin
                        run_cnt_d  = run_cnt_q;
                        rest_cnt_d = '0;
                        state_d    = S_REST;
                    end
                end
            end
            S_REST: begin
                // Rest length is fixed and does not depend on en.
                rest_cnt_d = rest_cnt_q + REST_W'(1);
                if (rest_cnt_q == REST_LAST) begin
                    rest_cnt_d = rest_cnt_q;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.v_out1     = v1_q;
    assign bus.v_out2     = v2_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_rate_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spike_rate_encoder
//  Description : Scoreboard bench for spike_rate_encoder. Stimulus pushes the
//                hand-computed per-frame expectation; a monitor records each
//                frame's spike traces and compares on frame_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_rate_encoder;

    localparam int IN_W = 4;

    typedef struct {
        int          c1;     // expected v_out1 pulses
        int          c2;     // expected v_out2 pulses
        int          blen;   // expected busy-high samples
        int          zfrom;  // first sample index that must be silent (REST)
        bit          chk;    // compare full traces
        logic [31:0] p1;     // trace of v_out1, bit k = sample after edge k
        logic [31:0] p2;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    spike_rate_encoder_if #(.IN_W(IN_W)) bus ();

    spike_rate_encoder #(
        .IN_W      (IN_W),
        .FRAME_LEN (16),
        .REST_LEN  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int c1, input int c2, input int blen, input int zfrom,
                                input bit chk_p, input logic [31:0] p1, input logic [31:0] p2);
        exp_t e;
        e.c1 = c1; e.c2 = c2; e.blen = blen; e.zfrom = zfrom;
        e.chk = chk_p; e.p1 = p1; e.p2 = p2;
        return e;
    endfunction

    // Monitor: sample between edges, build traces, score on frame_done.
    initial begin
        int          idx;
        int          bc;
        logic [63:0] t1;
        logic [63:0] t2;
        logic [63:0] mask;
        logic        prev_done;
        exp_t        e;
        idx = 0; bc = 0; t1 = '0; t2 = '0; prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                idx = 0; bc = 0; t1 = '0; t2 = '0; prev_done = 1'b0;
                continue;
            end
            if (prev_done) chk("done_single_cycle", 64'(bus.frame_done), 64'd0);
            prev_done = bus.frame_done;
            if (bus.busy || bus.frame_done) begin
                if (idx < 64) begin
                    t1[idx] = bus.v_out1;
                    t2[idx] = bus.v_out2;
                end
                idx++;
                if (bus.busy) bc++;
                if (bus.frame_done) begin
                    if (q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_frame_done: got a done pulse, required none");
                    end else begin
                        e = q.pop_front();
                        chk("spikes_ch1", 64'($countones(t1)), 64'(e.c1));
                        chk("spikes_ch2", 64'($countones(t2)), 64'(e.c2));
                        chk("busy_cycles", 64'(bc), 64'(e.blen));
                        mask = '0;
                        for (int i = 0; i < 64; i++)
                            if (i == 0 || i >= e.zfrom) mask[i] = 1'b1;
                        chk("rest_quiet", (t1 | t2) & mask, 64'd0);
                        if (e.chk) begin
                            chk("trace_ch1", t1, {32'd0, e.p1});
                            chk("trace_ch2", t2, {32'd0, e.p2});
                        end
                    end
                    idx = 0; bc = 0; t1 = '0; t2 = '0;
                end
            end else begin
                chk("idle_quiet", {62'd0, bus.v_out1, bus.v_out2}, 64'd0);
            end
        end
    end

    // Present a load for one edge (edge 0 of the frame).
    task automatic start(input int a, input int b, input bit push, input exp_t e);
        @(negedge clk);
        bus.load = 1'b1;
        bus.int1 = a[IN_W-1:0];
        bus.int2 = b[IN_W-1:0];
        if (push) q.push_back(e);
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while (k < bound) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) break;
            k++;
        end
        if (k >= bound) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: got no frame_done within %0d cycles, required one", bound);
        end
    endtask

    initial begin
        exp_t nx;
        nx = mk(0, 0, 0, 0, 1'b0, 32'd0, 32'd0);
        bus.en = 1'b1; bus.load = 1'b0; bus.int1 = '0; bus.int2 = '0;

        repeat (2) @(negedge clk);
        chk("reset_state", {60'd0, bus.v_out1, bus.v_out2, bus.busy, bus.frame_done}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame: carries at edges 4,7,10,13,16.
        start(5, 0, 1'b1, mk(5, 0, 20, 17, 1'b1, 32'h0001_2490, 32'h0));
        wait_done(40);

        // Half rate alternates from edge 2; full-scale fires on edges 2..16.
        start(8, 15, 1'b1, mk(8, 15, 20, 17, 1'b1, 32'h0001_5554, 32'h0001_FFFC));
        wait_done(40);

        // Three-cycle stall on edges 6..8 shifts later spikes and done by 3.
        start(4, 0, 1'b1, mk(4, 0, 23, 20, 1'b1, 32'h0008_8810, 32'h0));
        repeat (5) @(negedge clk);
        bus.en = 1'b0;
        repeat (3) @(negedge clk);
        bus.en = 1'b1;
        wait_done(40);

        // Load while busy is ignored; held through done it starts the next frame.
        start(3, 6, 1'b1, mk(3, 6, 20, 17, 1'b0, 32'h0, 32'h0));
        repeat (4) @(negedge clk);
        bus.load = 1'b1; bus.int1 = 4'd15; bus.int2 = 4'd15;
        q.push_back(mk(15, 15, 20, 17, 1'b1, 32'h0001_FFFC, 32'h0001_FFFC));
        wait_done(40);
        @(negedge clk);
        chk("back_to_back_busy", 64'(bus.busy), 64'd1);
        bus.load = 1'b0;
        wait_done(40);

        // Asynchronous reset mid-RUN aborts the frame with no done pulse.
        start(7, 7, 1'b0, nx);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {60'd0, bus.v_out1, bus.v_out2, bus.busy, bus.frame_done}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start(9, 3, 1'b1, mk(9, 3, 20, 17, 1'b0, 32'h0, 32'h0));
        wait_done(40);

        // Sweep: spike count equals intensity at the default frame length.
        for (int i = 0; i < 16; i++) begin
            start(i, 15 - i, 1'b1, mk(i, 15 - i, 20, 17, 1'b0, 32'h0, 32'h0));
            wait_done(40);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
